// File: rtl/mult_block_arbiter_pkg.sv
// rtl/mult_block_arbiter_pkg.sv - shared types for the block multiplier arbiter
package mult_block_arbiter_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DIM_WIDTH  = 16;
  localparam int DATA_WIDTH = 32;
  localparam int IDX_WIDTH  = 2;

  typedef logic [7:0][7:0][DATA_WIDTH-1:0] block_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] base_A;
    logic [ADDR_WIDTH-1:0] base_B;
    logic [DIM_WIDTH-1:0]  dim_col_A;
    logic [DIM_WIDTH-1:0]  dim_col_B;
  } mult_job_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESPOND   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mult_block_arbiter_rr_pick.sv
// rtl/mult_block_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  // Distance from the slot after last_grant; the smallest set distance wins.
  always_comb begin
    int best;
    int d;
    best      = N;
    d         = 0;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      d = (i + 4 * N - int'(last_grant) - 1) % N;
      if (req[i] && d < best) begin
        best      = d;
        grant_idx = IW'(i);
      end
    end
    any = (best < N);
    for (int i = 0; i < N; i++) begin
      grant[i] = any && (grant_idx == IW'(i));
    end
  end

endmodule

// File: rtl/mult_block_arbiter.sv
// rtl/mult_block_arbiter.sv - shares one 8x8 block multiplier among N_REQ clients
module mult_block_arbiter
  import mult_block_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [N_REQ-1:0]                     req_valid,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     req_base_A,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     req_base_B,
  input  logic [N_REQ-1:0][DIM_WIDTH-1:0]      req_dim_col_A,
  input  logic [N_REQ-1:0][DIM_WIDTH-1:0]      req_dim_col_B,
  output logic [N_REQ-1:0]                     req_ready,
  output logic [N_REQ-1:0]                     resp_valid,
  output logic                                 resp_err,
  output block_t                               resp_data,
  output logic                                 mult_start,
  output logic [ADDR_WIDTH-1:0]                base_A,
  output logic [ADDR_WIDTH-1:0]                base_B,
  output logic [DIM_WIDTH-1:0]                 dim_col_A,
  output logic [DIM_WIDTH-1:0]                 dim_col_B,
  input  logic                                 mult_done,
  input  block_t                               mult_out,
  output logic                                 busy,
  output logic [IDX_WIDTH-1:0]                 owner,
  output logic                                 timeout_flag
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

  arb_state_t             state_q, state_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   err_q, err_d;
  logic                   expire;
  logic [IDX_WIDTH-1:0]   last_grant;
  logic [N_REQ-1:0]       pick_grant;
  logic [IDX_WIDTH-1:0]   pick_idx;
  logic                   pick_any;
  mult_job_t              pick_job;
  mult_job_t              job_q;
  logic [N_REQ-1:0]       resp_valid_d;

  rr_pick #(.N(N_REQ), .IW(IDX_WIDTH)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .grant_idx  (pick_idx),
    .any        (pick_any)
  );

  assign req_ready = (state_q == IDLE && !reset) ? pick_grant : '0;

  always_comb begin
    pick_job = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) begin
        pick_job.base_A    = req_base_A[i];
        pick_job.base_B    = req_base_B[i];
        pick_job.dim_col_A = req_dim_col_A[i];
        pick_job.dim_col_B = req_dim_col_B[i];
      end
    end
  end

  // A completion arriving in the expiry cycle takes precedence over the abort.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_d   = err_q;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) state_d = ISSUE;
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mult_done) begin
          err_d   = 1'b0;
          state_d = RESPOND;
        end else if (wd_q == WD_LAST) begin
          expire  = 1'b1;
          err_d   = 1'b1;
          state_d = RESPOND;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      resp_valid_d[i] = (state_d == RESPOND) && (owner == IDX_WIDTH'(i));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wd_q         <= '0;
      err_q        <= 1'b0;
      last_grant   <= IDX_WIDTH'(N_REQ - 1);
      job_q        <= '0;
      owner        <= '0;
      resp_data    <= '0;
      resp_valid   <= '0;
      resp_err     <= 1'b0;
      mult_start   <= 1'b0;
      busy         <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      mult_start <= (state_d == ISSUE);
      busy       <= (state_d != IDLE);
      resp_valid <= resp_valid_d;
      resp_err   <= (state_d == RESPOND) && err_d;
      if (state_q == IDLE && pick_any) begin
        job_q <= pick_job;
        owner <= pick_idx;
      end
      if (state_q == WAIT_DONE && mult_done) resp_data <= mult_out;
      if (expire) timeout_flag <= 1'b1;
      if (state_q == RESPOND) last_grant <= owner;
    end
  end

  assign base_A    = job_q.base_A;
  assign base_B    = job_q.base_B;
  assign dim_col_A = job_q.dim_col_A;
  assign dim_col_B = job_q.dim_col_B;

endmodule

// File: tb/tb_mult_block_arbiter.sv
// tb/tb_mult_block_arbiter.sv - directed bench for mult_block_arbiter
module tb_mult_block_arbiter;
  import mult_block_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int TO = 16;

  logic                         clock = 1'b0;
  logic                         reset = 1'b1;
  logic [NR-1:0]                req_valid = '0;
  logic [NR-1:0][ADDR_WIDTH-1:0] req_base_A = '0;
  logic [NR-1:0][ADDR_WIDTH-1:0] req_base_B = '0;
  logic [NR-1:0][DIM_WIDTH-1:0]  req_dim_col_A = '0;
  logic [NR-1:0][DIM_WIDTH-1:0]  req_dim_col_B = '0;
  logic [NR-1:0]                req_ready;
  logic [NR-1:0]                resp_valid;
  logic                         resp_err;
  block_t                       resp_data;
  logic                         mult_start;
  logic [ADDR_WIDTH-1:0]        base_A, base_B;
  logic [DIM_WIDTH-1:0]         dim_col_A, dim_col_B;
  logic                         mult_done = 1'b0;
  block_t                       mult_out = '0;
  logic                         busy;
  logic [1:0]                   owner;
  logic                         timeout_flag;

  mult_block_arbiter #(.N_REQ(NR), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid),
    .req_base_A(req_base_A), .req_base_B(req_base_B),
    .req_dim_col_A(req_dim_col_A), .req_dim_col_B(req_dim_col_B),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_data(resp_data), .mult_start(mult_start),
    .base_A(base_A), .base_B(base_B), .dim_col_A(dim_col_A), .dim_col_B(dim_col_B),
    .mult_done(mult_done), .mult_out(mult_out), .busy(busy), .owner(owner),
    .timeout_flag(timeout_flag)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          rst;
    logic [2:0]  mask;
    int          lat;
    int          win;
    bit          err;
    logic [31:0] ba;
    logic [31:0] bb;
    logic [15:0] dim;
  } row_t;

  row_t   rows[10];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     prev_grant = 0;
  int     prev_lat = 0;
  block_t exp_data = '0;
  bit     exp_flag = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
    cyc++;
  endtask

  function automatic block_t blk(input int r);
    block_t b;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        b[i][j] = (r == 0) ? 32'h3F80_0000 : (32'hA000_0000 | 32'(r << 16) | 32'(i << 8) | 32'(j));
    return b;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '1;
    mult_done = 1'b0;
    #1;
    tick();
    tick();
    chk("rst_ctl", {req_ready, resp_valid, resp_err, mult_start, busy, owner, timeout_flag}, 0);
    chk("rst_base", {base_A, base_B}, 0);
    chk("rst_dim", {dim_col_A, dim_col_B}, 0);
    chk("rst_data", resp_data == '0, 1);
    req_valid = '0;
    reset = 1'b0;
    exp_data = '0;
    exp_flag = 1'b0;
    #1;
  endtask

  task automatic run_job(input row_t r, input int idx);
    int c;
    bit got, extra;
    logic [2:0] w1;
    if (r.rst) do_reset();
    for (int i = 0; i < NR; i++) begin
      req_base_A[i]    = r.ba + 32'(i) * 32'h1000;
      req_base_B[i]    = r.bb + 32'(i) * 32'h1000;
      req_dim_col_A[i] = r.dim + 16'(i);
      req_dim_col_B[i] = r.dim + 16'(2 * i);
    end
    req_valid = r.mask;
    mult_out  = blk(idx);
    mult_done = 1'b0;
    #1;
    w1 = 3'b001 << r.win;
    chk("grant", req_ready, w1);
    if (!r.rst) chk("spacing", cyc - prev_grant, prev_lat + 3);
    prev_grant = cyc;
    prev_lat   = (r.lat > 0) ? r.lat : TO - 1;
    tick();
    chk("mult_start", mult_start, 1);
    chk("base_A", base_A, r.ba + 32'(r.win) * 32'h1000);
    chk("base_B", base_B, r.bb + 32'(r.win) * 32'h1000);
    chk("dims", {dim_col_A, dim_col_B}, {r.dim + 16'(r.win), r.dim + 16'(2 * r.win)});
    chk("owner", {busy, owner}, {1'b1, 2'(r.win)});
    c = 0; got = 0; extra = 0;
    while (c < 40 && !got) begin
      mult_done = (r.lat > 0 && c == r.lat);
      tick();
      c++;
      mult_done = 1'b0;
      if (|resp_valid) got = 1;
      else if (req_ready != 0 || mult_start) extra = 1;
    end
    chk("no_extra_pulse", extra, 0);
    chk("resp_cycle", c, (r.lat > 0) ? r.lat + 1 : TO);
    chk("resp_valid", resp_valid, w1);
    chk("resp_err", resp_err, r.err);
    if (!r.err) exp_data = blk(idx);
    chk("resp_data", resp_data == exp_data, 1);
    if (r.err) exp_flag = 1'b1;
    chk("timeout_flag", timeout_flag, exp_flag);
    tick();
    chk("back_idle", {busy, resp_valid, resp_err}, 0);
  endtask

  initial begin
    bit seen;
    rows[0] = '{1'b1, 3'b001,  5, 0, 1'b0, 32'h100, 32'h200, 16'd16};
    rows[1] = '{1'b1, 3'b011,  3, 0, 1'b0, 32'h300, 32'h400, 16'd8};
    rows[2] = '{1'b0, 3'b011,  2, 1, 1'b0, 32'h310, 32'h410, 16'd9};
    rows[3] = '{1'b0, 3'b011,  4, 0, 1'b0, 32'h320, 32'h420, 16'd10};
    rows[4] = '{1'b0, 3'b011,  1, 1, 1'b0, 32'h330, 32'h430, 16'd11};
    rows[5] = '{1'b0, 3'b011,  2, 0, 1'b0, 32'h340, 32'h440, 16'd12};
    rows[6] = '{1'b0, 3'b111,  3, 1, 1'b0, 32'h350, 32'h450, 16'd13};
    rows[7] = '{1'b0, 3'b111,  0, 2, 1'b1, 32'h360, 32'h460, 16'd14};
    rows[8] = '{1'b0, 3'b111, 15, 0, 1'b0, 32'h370, 32'h470, 16'd15};
    rows[9] = '{1'b0, 3'b111, 14, 1, 1'b0, 32'h380, 32'h480, 16'd16};

    for (int k = 0; k < 10; k++) run_job(rows[k], k);

    // mult_done while idle must not disturb anything
    req_valid = '0;
    mult_out  = blk(99);
    mult_done = 1'b1;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (busy || mult_start || resp_valid != 0) seen = 1;
    end
    mult_done = 1'b0;
    chk("spurious_done", seen, 0);
    chk("spurious_data", resp_data == exp_data, 1);

    // reset while waiting for the multiplier drops the job
    req_valid = 3'b001;
    #1;
    tick();
    req_valid = '0;
    chk("mid_start", mult_start, 1);
    tick();
    tick();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ctl", {req_ready, resp_valid, resp_err, mult_start, busy, owner, timeout_flag}, 0);
    chk("mid_rst_ops", {base_A, base_B}, 0);
    chk("mid_rst_data", resp_data == '0, 1);
    tick();
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (resp_valid != 0 || busy) seen = 1;
    end
    chk("mid_no_resp", seen, 0);
    req_valid = 3'b111;
    #1;
    chk("mid_regrant", req_ready, 3'b001);
    tick();
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_block_arbiter.md
# mult_block_arbiter

Round-robin arbiter and sequencer that shares the single 8×8 block multiplier between up to four block-level clients, e.g. the large-matrix multiply driver and a future transpose/convolution driver. Each client posts one block job (two base addresses, two column dimensions). The arbiter grants one job, launches the multiplier, waits for completion, and returns the 8×8 result block to the granted client. A watchdog flags a multiplier that never completes.

## Interface
- N_REQ, 2, number of clients (2..4)
- TIMEOUT, 4096, cycles allowed in WAIT_DONE before abort
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- req_valid  in  N_REQ  client i has a job pending; held until req_ready[i]
- req_base_A, req_base_B  in  N_REQ×ADDR_WIDTH  block base addresses per client
- req_dim_col_A, req_dim_col_B  in  N_REQ×DIM_WIDTH  column dims per client
- req_ready  out  N_REQ  one-cycle accept pulse, one-hot
- resp_valid  out  N_REQ  one-cycle result pulse, one-hot, to the owning client
- resp_err  out  1  qualifies resp_valid: job aborted by timeout
- resp_data  out  8×8×DATA_WIDTH  registered result block, broadcast to all clients, valid with resp_valid
- mult_start  out  1  one-cycle launch pulse to the multiplier
- base_A, base_B  out  ADDR_WIDTH  registered operands to the multiplier
- dim_col_A, dim_col_B  out  DIM_WIDTH  registered operands to the multiplier
- mult_done  in  1  multiplier completion pulse
- mult_out  in  8×8×DATA_WIDTH  multiplier result, valid with mult_done
- busy  out  1  state ≠ IDLE
- owner  out  2  index of the granted client; meaningful while busy
- timeout_flag  out  1  sticky; set on any abort, cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT_DONE, RESPOND.
- IDLE:
  - If any req_valid is set, pick the first set index searching from last_grant+1 and wrapping modulo N_REQ.
  - Assert req_ready[winner] combinationally in the same cycle.
  - Latch the winner's operands into base_*/dim_col_*, set owner, and go to ISSUE.
- ISSUE: mult_start=1 for exactly one cycle, clear the watchdog, go to WAIT_DONE.
- WAIT_DONE:
  - On mult_done, register mult_out into resp_data, set err_q=0, and go to RESPOND.
  - Otherwise increment the watchdog. When it reaches TIMEOUT−1, set err_q=1, set timeout_flag, leave resp_data unchanged, and go to RESPOND.
- RESPOND: resp_valid[owner]=1 and resp_err=err_q for one cycle, last_grant←owner, go to IDLE.
- Ignored inputs:
  - mult_done outside WAIT_DONE is ignored.
  - Operand inputs of non-winning or non-requesting clients are ignored.
- Operand registers hold their value from the grant until the next grant.
- Simultaneous mult_done and watchdog expiry: mult_done wins and there is no error.
- A client deasserting req_valid before it is granted is legal; that job is simply not taken.
- Reset values:
  - State IDLE.
  - last_grant=N_REQ−1, so client 0 wins first after reset.
  - All outputs 0: req_ready, resp_valid, resp_err, resp_data, mult_start, base_*, dim_col_*, busy, owner, timeout_flag.
- Reset mid-job drops the job silently with no resp_valid. The client must re-request.

## Timing
- Grant at cycle t (req_ready high).
- mult_start at t+1.
- With mult_done at t+1+L (L≥1), resp_valid is at t+2+L.
- IDLE lasts at least one cycle between jobs, so back-to-back grants are spaced L+3 cycles apart.
- No client waits more than N_REQ−1 other jobs once it asserts req_valid (round-robin fairness).
- All outputs are registered except req_ready, which is combinational from req_valid, state and last_grant.

## Structure
- Shared package (Macro.svh / common typedefs):
  - mult_job_t packed struct {base_A, base_B, dim_col_A, dim_col_B}
  - block_t as [7:0][7:0][DATA_WIDTH-1:0]
  - arb_state_t enum
- One sub-module, rr_pick: pure combinational round-robin priority picker over N_REQ bits with a last_grant input. It returns the one-hot grant and its index, and is reusable for a later memory-port arbiter.
- Watchdog width: $clog2(TIMEOUT).

## Test plan
- Single client: after reset, req_valid[0] with base_A=0x100, base_B=0x200, dims=16. Expect req_ready[0] in the same cycle and mult_start next cycle with those operands. Model mult_done after L=5 with a block of all 0x3F800000. Expect resp_valid[0] one cycle later, resp_data matching and resp_err=0.
- Contention: req_valid=2'b11 held continuously from reset. Expect grants in order 0,1,0,1 with exactly one req_ready per job and spacing L+3.
- Fairness with 3 clients: client 2 requests while 0 and 1 are saturating. Expect client 2 granted no later than the third job.
- Timeout: never assert mult_done with TIMEOUT=16. Expect resp_valid[owner] with resp_err=1 16 cycles after mult_start, timeout_flag stuck at 1, and the next job served normally.
- Spurious and simultaneous events:
  - mult_done pulsed during IDLE is ignored.
  - mult_done in the same cycle as watchdog expiry gives resp_err=0.
- Reset mid-job: assert reset during WAIT_DONE. Expect all outputs 0 and no resp_valid. Client 0 wins the next arbitration.
